// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory subsystem: memory geometry defaults,
// requester port indices and the memory-arbiter state encoding.
package cpu_mem_pkg;

    localparam int DEF_AW = 8;
    localparam int DEF_DW = 32;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester handshakes (CPU, debug) and the shared memory bus.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface mem_port_arbiter_if
    import cpu_mem_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) ();

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_done;
    logic [DW-1:0] cpu_rdata;

    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_gnt;
    logic          dbg_done;
    logic [DW-1:0] dbg_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_done, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_done, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_done, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_done, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester always wins,
// on contention the port that did not win last time gets the grant.
module rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_last_owner,
    output logic [1:0] o_gnt,
    output logic       o_winner
);

    assign o_winner = (i_req == 2'b11) ? ~i_last_owner : i_req[1];
    assign o_gnt    = {o_winner, ~o_winner} & {2{|i_req}};

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU and debug accesses onto the single unified memory, one
// transaction at a time, with a req/gnt/done handshake per port.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);

    arb_state_e    r_state;
    logic          r_owner;
    logic          r_last_owner;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_mem_en;
    logic          r_mem_we;
    logic          r_cpu_done;
    logic          r_dbg_done;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_dbg_rdata;

    logic [1:0]    w_req;
    logic [1:0]    w_pick;
    logic [1:0]    w_gnt;
    logic          w_winner;
    logic          w_idle;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    assign w_req = {bus.dbg_req, bus.cpu_req};

    rr_pick2 u_pick (
        .i_req        (w_req),
        .i_last_owner (r_last_owner),
        .o_gnt        (w_pick),
        .o_winner     (w_winner)
    );

    // Grants only exist in IDLE; rst_n gating keeps gnt at 0 while reset is held.
    assign w_idle      = (r_state == IDLE) && rst_n;
    assign w_gnt       = w_idle ? w_pick : 2'b00;
    assign w_sel_we    = (w_winner == PORT_DBG) ? bus.dbg_we    : bus.cpu_we;
    assign w_sel_addr  = (w_winner == PORT_DBG) ? bus.dbg_addr  : bus.cpu_addr;
    assign w_sel_wdata = (w_winner == PORT_DBG) ? bus.dbg_wdata : bus.cpu_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_owner      <= PORT_CPU;
            r_last_owner <= PORT_DBG;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_cpu_done   <= 1'b0;
            r_dbg_done   <= 1'b0;
            r_cpu_rdata  <= '0;
            r_dbg_rdata  <= '0;
        end else begin
            r_cpu_done <= 1'b0;
            r_dbg_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|w_gnt) begin
                        r_owner      <= w_winner;
                        r_last_owner <= w_winner;
                        r_we         <= w_sel_we;
                        r_addr       <= w_sel_addr;
                        r_wdata      <= w_sel_wdata;
                        r_mem_en     <= 1'b1;
                        r_mem_we     <= w_sel_we;
                        // A write completes in the ACCESS cycle itself.
                        r_cpu_done   <= w_sel_we && (w_winner == PORT_CPU);
                        r_dbg_done   <= w_sel_we && (w_winner == PORT_DBG);
                        r_state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                    if (r_we) begin
                        r_state <= IDLE;
                    end else begin
                        r_cpu_done <= (r_owner == PORT_CPU);
                        r_dbg_done <= (r_owner == PORT_DBG);
                        r_state    <= RESP;
                    end
                end
                RESP: begin
                    if (r_owner == PORT_CPU) begin
                        r_cpu_rdata <= bus.mem_rdata;
                    end else begin
                        r_dbg_rdata <= bus.mem_rdata;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cpu_gnt   = w_gnt[PORT_CPU];
    assign bus.dbg_gnt   = w_gnt[PORT_DBG];
    assign bus.cpu_done  = r_cpu_done;
    assign bus.dbg_done  = r_dbg_done;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;

    // The memory's output register is forwarded during RESP so data lines up with done.
    assign bus.cpu_rdata = (r_state == RESP && r_owner == PORT_CPU) ? bus.mem_rdata : r_cpu_rdata;
    assign bus.dbg_rdata = (r_state == RESP && r_owner == PORT_DBG) ? bus.mem_rdata : r_dbg_rdata;

endmodule
